// File: rtl/aggregator_window_max.sv
// aggregator_window_max
//
// Sits behind the binary aggregator comparator tree and folds its per-cycle
// winner stream into windows. For each window it keeps the largest key seen
// and that key's data. The earliest entry wins on equal keys, which matches
// the tree. When a window closes, the result is presented on a valid/ready
// port. The block then stops accepting samples until the result is taken.
//
// A window closes in one of two ways:
//   - win_len samples have been accepted. win_len is latched on the window's
//     first sample, and a value of 0 is treated as 1.
//   - flush is asserted while the window holds data, or while a sample is
//     being accepted in the same cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   key_in    winner key from the comparator tree
//   data_in   winner data from the comparator tree
//   vld_in    winner valid from the comparator tree
//   rdy_in    high while a sample can be accepted (ACCUM state)
//   win_len   samples per window, latched at window start
//   flush     close the current window early
//   out_key   max key of the closed window
//   out_data  data paired with out_key
//   out_cnt   number of samples in the closed window
//   out_vld   result valid
//   out_rdy   downstream accepts the result
module aggregator_window_max #(
    parameter int KEY_WIDTH  = 3,
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  vld_in,
    output logic                  rdy_in,
    input  logic [CNT_WIDTH-1:0]  win_len,
    input  logic                  flush,
    output logic [KEY_WIDTH-1:0]  out_key,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_cnt,
    output logic                  out_vld,
    input  logic                  out_rdy
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [KEY_WIDTH-1:0]  best_key_q;
    logic [DATA_WIDTH-1:0] best_data_q;

    logic                  accept;
    logic                  take;
    logic                  close;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [CNT_WIDTH-1:0]  eff_len;
    logic [CNT_WIDTH-1:0]  nxt_cnt;
    logic [KEY_WIDTH-1:0]  nxt_key;
    logic [DATA_WIDTH-1:0] nxt_data;

    assign rdy_in = (state_q == ACCUM);

    always_comb begin
        accept   = vld_in && (state_q == ACCUM);
        cnt_inc  = cnt_q + 1'b1;

        // On the first sample the length is not yet latched, so the
        // freshly clamped win_len decides whether a 1-sample window closes.
        if (cnt_q == '0) begin
            eff_len = (win_len == '0) ? CNT_WIDTH'(1) : win_len;
        end else begin
            eff_len = len_q;
        end

        // A strict compare keeps the incumbent on ties.
        take     = accept && ((cnt_q == '0) || (key_in > best_key_q));
        nxt_key  = take ? key_in : best_key_q;
        nxt_data = take ? data_in : best_data_q;
        nxt_cnt  = accept ? cnt_inc : cnt_q;

        close = (state_q == ACCUM) &&
                ((accept && (cnt_inc == eff_len)) ||
                 (flush && ((cnt_q != '0) || accept)));

        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)   state_d = HOLD;
            HOLD:    if (out_rdy) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            best_key_q  <= '0;
            best_data_q <= '0;
            out_key     <= '0;
            out_data    <= '0;
            out_cnt     <= '0;
            out_vld     <= 1'b0;
        end else if (state_q == ACCUM) begin
            if (accept) begin
                cnt_q       <= cnt_inc;
                best_key_q  <= nxt_key;
                best_data_q <= nxt_data;
                if (cnt_q == '0) begin
                    len_q <= eff_len;
                end
            end
            if (close) begin
                out_key  <= nxt_key;
                out_data <= nxt_data;
                out_cnt  <= nxt_cnt;
                out_vld  <= 1'b1;
            end
        end else begin
            // HOLD: the result stays put until the downstream takes it.
            // Then the window state is cleared for the next window.
            if (out_rdy) begin
                out_vld     <= 1'b0;
                cnt_q       <= '0;
                best_key_q  <= '0;
                best_data_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aggregator_window_max.sv
module tb_aggregator_window_max;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_in;
    logic [3:0] data_in;
    logic       vld_in;
    logic       rdy_in;
    logic [7:0] win_len;
    logic       flush;
    logic [2:0] out_key;
    logic [3:0] out_data;
    logic [7:0] out_cnt;
    logic       out_vld;
    logic       out_rdy;

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 0;

    aggregator_window_max #(.KEY_WIDTH(3), .DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .data_in(data_in),
        .vld_in(vld_in), .rdy_in(rdy_in), .win_len(win_len), .flush(flush),
        .out_key(out_key), .out_data(out_data), .out_cnt(out_cnt),
        .out_vld(out_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the current window is a list of accepted samples. The result
    // is the first sample holding the largest key.
    typedef struct {
        int k;
        int d;
    } smp_t;

    smp_t win_q[$];
    int   m_len  = 1;
    bit   m_hold = 0;
    int   m_key  = 0;
    int   m_data = 0;
    int   m_cnt  = 0;
    bit   m_vld  = 0;

    always @(posedge clk) begin
        if (rst) begin
            win_q.delete();
            m_hold = 0;
            m_vld  = 0;
            m_key  = 0;
            m_data = 0;
            m_cnt  = 0;
        end else if (m_hold) begin
            if (out_rdy) begin
                m_hold = 0;
                m_vld  = 0;
                win_q.delete();
            end
        end else begin
            smp_t s;
            bit   closing;
            if (vld_in) begin
                if (win_q.size() == 0) begin
                    m_len = (win_len == 0) ? 1 : int'(win_len);
                end
                s.k = int'(key_in);
                s.d = int'(data_in);
                win_q.push_back(s);
            end
            closing = (vld_in && win_q.size() == m_len) ||
                      (flush && win_q.size() > 0);
            if (closing) begin
                smp_t best;
                best = win_q[0];
                foreach (win_q[i]) begin
                    if (win_q[i].k > best.k) best = win_q[i];
                end
                m_key  = best.k;
                m_data = best.d;
                m_cnt  = win_q.size();
                m_vld  = 1;
                m_hold = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rdy_in", int'(rdy_in), int'(!m_hold));
            chk("out_vld", int'(out_vld), int'(m_vld));
            if (m_vld) begin
                chk("out_key", int'(out_key), m_key);
                chk("out_data", int'(out_data), m_data);
                chk("out_cnt", int'(out_cnt), m_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int d);
        vld_in  = 1'b1;
        key_in  = 3'(k);
        data_in = 4'(d);
        step();
        vld_in  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int k, input int d, input int c);
        chk({tag, "_vld"}, int'(out_vld), 1);
        chk({tag, "_rdy_in"}, int'(rdy_in), 0);
        chk({tag, "_key"}, int'(out_key), k);
        chk({tag, "_data"}, int'(out_data), d);
        chk({tag, "_cnt"}, int'(out_cnt), c);
    endtask

    task automatic release_result(input string tag);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk({tag, "_released_vld"}, int'(out_vld), 0);
        chk({tag, "_released_rdy"}, int'(rdy_in), 1);
    endtask

    initial begin
        rst = 1'b1; vld_in = 1'b0; key_in = '0; data_in = '0;
        win_len = '0; flush = 1'b0; out_rdy = 1'b0;
        step();
        started = 1;
        step();
        chk("reset_rdy_in", int'(rdy_in), 1);
        chk("reset_out_vld", int'(out_vld), 0);
        chk("reset_out_key", int'(out_key), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_cnt", int'(out_cnt), 0);
        rst = 1'b0;

        // Basic 3-sample window; hold while out_rdy is low.
        win_len = 8'd3;
        send(2, 1); send(5, 9); send(1, 3);
        expect_result("w3", 5, 9, 3);
        step(); step();
        expect_result("w3_held", 5, 9, 3);
        release_result("w3");

        // Tie on key 6: the earliest data (10) must win.
        win_len = 8'd4;
        send(6, 10); send(6, 11); send(3, 1); send(6, 12);
        expect_result("tie", 6, 10, 4);
        release_result("tie");

        // Early flush with no sample, then a lone flush that must be ignored.
        win_len = 8'd5;
        send(1, 2); send(4, 7);
        flush = 1'b1; step(); flush = 1'b0;
        expect_result("flush", 4, 7, 2);
        release_result("flush");
        flush = 1'b1; step(); flush = 1'b0;
        chk("lone_flush_vld", int'(out_vld), 0);
        step();
        chk("lone_flush_vld2", int'(out_vld), 0);

        // Flush together with a valid sample: the sample is included.
        send(2, 1);
        flush = 1'b1; send(4, 2); flush = 1'b0;
        expect_result("flush_vld", 4, 2, 2);
        release_result("flush_vld");

        // win_len=0 behaves as 1; HOLD ignores samples and flush for 3 cycles.
        win_len = 8'd0;
        send(7, 5);
        expect_result("len0", 7, 5, 1);
        vld_in = 1'b1; key_in = 3'd3; data_in = 4'd1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_result("len0_hold", 7, 5, 1);
        end
        vld_in = 1'b0; flush = 1'b0;
        release_result("len0");

        // Changing win_len mid-window has no effect; the next window uses 8.
        win_len = 8'd2;
        send(1, 1);
        win_len = 8'd8;
        send(2, 2);
        expect_result("len_change", 2, 2, 2);
        release_result("len_change");
        begin
            int ks[8] = '{3, 0, 7, 1, 7, 2, 4, 5};
            for (int i = 0; i < 8; i++) begin
                if (i == 7) chk("len8_not_early", int'(out_vld), 0);
                send(ks[i], i);
            end
        end
        expect_result("len8", 7, 2, 8);
        release_result("len8");

        // Reset mid-window discards the partial window entirely.
        win_len = 8'd4;
        send(7, 1); send(6, 2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_vld", int'(out_vld), 0);
        chk("midrst_rdy", int'(rdy_in), 1);
        send(1, 3);
        send(3, 4);
        send(2, 5);
        chk("midrst_no_early", int'(out_vld), 0);
        send(0, 6);
        expect_result("after_rst", 3, 4, 4);
        release_result("after_rst");

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
